// File: rtl/bcd_interval_timer_ctrl_if.sv
// bcd_interval_timer_ctrl_if: command/status bundle between command logic (master) and the BCD interval timer (slave)
//   cfg_valid/cfg_ready/cfg_value/cfg_err : load handshake and rejection pulse
//   start/pause/stop                      : run control commands
//   busy/done/remaining/c_enable          : timer status and per-digit borrow enables
interface bcd_interval_timer_ctrl_if #(
  parameter int DIGITS = 3
);
  logic cfg_valid, cfg_ready, cfg_err;
  logic start, pause, stop;
  logic busy, done;
  logic [4*DIGITS-1:0] cfg_value, remaining;
  logic [DIGITS-1:0] c_enable;
  modport master (
    output cfg_valid, cfg_value, start, pause, stop,
    input  cfg_ready, cfg_err, busy, done, remaining, c_enable
  );
  modport slave (
    input  cfg_valid, cfg_value, start, pause, stop,
    output cfg_ready, cfg_err, busy, done, remaining, c_enable
  );
endinterface

// File: rtl/bcd_interval_timer_ctrl.sv
// bcd_interval_timer_ctrl: prescaled BCD down-counter sequencer (load/start/pause/stop, done pulse at zero)
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : slave side of bcd_interval_timer_ctrl_if (load handshake, commands, status, c_enable)
module bcd_interval_timer_ctrl #(
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 1000
) (
  input logic clk,
  input logic reset,
  bcd_interval_timer_ctrl_if.slave bus
);
  localparam int PW = $clog2(PRESCALE + 1);
  localparam int W  = 4 * DIGITS;
  typedef enum logic [2:0] {IDLE, ARMED, RUN, PAUSE, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [W-1:0] rem, rem_n, dec;
  logic [DIGITS-1:0] ce;
  logic tick, cfg_ok, err_n, err_q, done_q, busy_q;
  assign tick = state == RUN && presc == PW'(PRESCALE - 1);
  // Borrow ripples upward only through digits that are already zero
  always_comb begin
    cfg_ok = 1'b1;
    dec = rem;
    ce = '0;
    ce[0] = tick;
    for (int i = 1; i < DIGITS; i++) ce[i] = ce[i-1] & (rem[4*i-4 +: 4] == 4'd0);
    for (int i = 0; i < DIGITS; i++) begin
      dec[4*i +: 4] = ce[i] ? (rem[4*i +: 4] == 4'd0 ? 4'd9 : rem[4*i +: 4] - 4'd1) : rem[4*i +: 4];
      if (bus.cfg_value[4*i +: 4] > 4'd9) cfg_ok = 1'b0;
    end
  end
  always_comb begin
    state_n = state;
    rem_n = rem;
    presc_n = presc;
    err_n = 1'b0;
    case (state)
      IDLE:
        if (bus.cfg_valid) begin
          if (cfg_ok) begin
            rem_n = bus.cfg_value;
            presc_n = '0;
            state_n = ARMED;
          end else err_n = 1'b1;
        end
      ARMED:
        if (bus.stop) begin
          rem_n = '0;
          state_n = IDLE;
        end else if (bus.start) state_n = rem == '0 ? DONE : RUN;
      RUN:
        if (bus.stop) begin
          rem_n = '0;
          presc_n = '0;
          state_n = IDLE;
        end else begin
          presc_n = tick ? '0 : presc + PW'(1);
          rem_n = tick ? dec : rem;
          if (tick && rem == W'(1)) state_n = DONE;
          else if (bus.pause) state_n = PAUSE;
        end
      PAUSE:
        if (bus.stop) begin
          rem_n = '0;
          presc_n = '0;
          state_n = IDLE;
        end else if (bus.start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rem <= '0;
      presc <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      presc <= presc_n;
      err_q <= err_n;
      done_q <= state_n == DONE;
      busy_q <= state_n != IDLE;
    end
  assign bus.cfg_ready = state == IDLE;
  assign bus.cfg_err = err_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.remaining = rem;
  assign bus.c_enable = ce;
endmodule

// File: tb/tb_bcd_interval_timer_ctrl.sv
// tb_bcd_interval_timer_ctrl: scoreboard bench with decimal reference model for the BCD interval timer
module tb_bcd_interval_timer_ctrl;
  localparam int D = 3;
  localparam int P = 4;
  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
  typedef struct {int cyc; bit is_done;} ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;
  bcd_interval_timer_ctrl_if #(.DIGITS(D)) bus();
  bcd_interval_timer_ctrl #(.DIGITS(D), .PRESCALE(P)) dut (.clk(clk), .reset(reset), .bus(bus));
  ev_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0, last_done = -1, drive_edge = 0;
  int m_mode = M_IDLE, m_cnt = 0, m_ph = 0;
  bit mon_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [11:0] to_bcd(int n);
    logic [11:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((n / (10 ** i)) % 10);
    return r;
  endfunction
  function automatic bit bcd_ok(logic [11:0] v);
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction
  function automatic int to_dec(logic [11:0] v);
    int n = 0;
    for (int i = D - 1; i >= 0; i--) n = n * 10 + int'(v[4*i +: 4]);
    return n;
  endfunction
  task automatic push(bit d);
    ev_t e;
    e.cyc = cyc + 1;
    e.is_done = d;
    q.push_back(e);
  endtask
  // Reference: count kept as a decimal integer, prescaler as a phase within the current tick
  task automatic model_step(bit v, logic [11:0] val, bit st, bit pa, bit sp);
    bit t;
    case (m_mode)
      M_IDLE:
        if (v) begin
          if (bcd_ok(val)) begin
            m_cnt = to_dec(val);
            m_ph = 0;
            m_mode = M_ARMED;
          end else push(1'b0);
        end
      M_ARMED:
        if (sp) begin
          m_mode = M_IDLE;
          m_cnt = 0;
        end else if (st) begin
          if (m_cnt == 0) begin
            m_mode = M_DONE;
            push(1'b1);
          end else m_mode = M_RUN;
        end
      M_RUN:
        if (sp) begin
          m_mode = M_IDLE;
          m_cnt = 0;
          m_ph = 0;
        end else begin
          m_ph++;
          t = m_ph == P;
          if (t) begin
            m_ph = 0;
            m_cnt--;
          end
          if (t && m_cnt == 0) begin
            m_mode = M_DONE;
            push(1'b1);
          end else if (pa) m_mode = M_PAUSE;
        end
      M_PAUSE:
        if (sp) begin
          m_mode = M_IDLE;
          m_cnt = 0;
          m_ph = 0;
        end else if (st) m_mode = M_RUN;
      default: m_mode = M_IDLE;
    endcase
  endtask
  task automatic drive(bit v, logic [11:0] val, bit st, bit pa, bit sp);
    @(negedge clk);
    #1;
    bus.cfg_valid = v;
    bus.cfg_value = val;
    bus.start = st;
    bus.pause = pa;
    bus.stop = sp;
    drive_edge = cyc + 1;
    model_step(v, val, st, pa, sp);
  endtask
  task automatic idle(int n);
    repeat (n) drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic load(logic [11:0] v);
    drive(1'b1, v, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic go(output int e0);
    drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
    e0 = drive_edge;
  endtask
  task automatic wait_done(int e0);
    for (int i = 0; i < 400 && last_done < e0; i++) idle(1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    bus.cfg_value = '0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.stop = 1'b0;
    #2 reset = 1'b1;
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.cfg_err, 0);
    chk("rst_remaining", bus.remaining, 0);
    chk("rst_ready", bus.cfg_ready, 1);
    chk("rst_queue_empty", q.size(), 0);
    m_mode = M_IDLE;
    m_cnt = 0;
    m_ph = 0;
    #2 reset = 1'b0;
    #2 chk("rst_ready_after", bus.cfg_ready, 1);
  endtask
  // Monitor: compares DUT outputs against the model and the queued done/cfg_err events each cycle
  always begin
    bit ed, ee;
    logic [2:0] ece;
    @(posedge clk);
    #2;
    if (mon_en) begin
      ed = 1'b0;
      ee = 1'b0;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        if (q[0].cyc == cyc) begin
          if (q[0].is_done) ed = 1'b1;
          else ee = 1'b1;
        end
        void'(q.pop_front());
      end
      for (int i = 0; i < D; i++) ece[i] = m_mode == M_RUN && m_ph == P - 1 && m_cnt % (10 ** i) == 0;
      chk("done", bus.done, ed);
      chk("cfg_err", bus.cfg_err, ee);
      chk("remaining", bus.remaining, to_bcd(m_cnt));
      chk("busy", bus.busy, m_mode != M_IDLE);
      chk("cfg_ready", bus.cfg_ready, m_mode == M_IDLE);
      chk("c_enable", bus.c_enable, ece);
      if (bus.done) last_done = cyc;
    end
  end
  initial begin
    int e0;
    logic [11:0] val;
    bus.cfg_valid = 1'b0;
    bus.cfg_value = '0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.stop = 1'b0;
    do_reset();
    mon_en = 1'b1;
    load(12'h003);
    go(e0);
    wait_done(e0);
    chk("t1_latency", last_done - e0, 12);
    idle(2);
    load(12'h100);
    go(e0);
    idle(4);
    chk("t2_c_enable", bus.c_enable, 3'b111);
    idle(1);
    chk("t2_remaining", bus.remaining, 12'h099);
    drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
    idle(1);
    load(12'h005);
    go(e0);
    idle(5);
    drive(1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    idle(9);
    drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
    wait_done(e0);
    chk("t3_latency", last_done - e0, 30);
    idle(2);
    load(12'h0A2);
    idle(1);
    chk("t4_err", bus.cfg_err, 1);
    chk("t4_ready", bus.cfg_ready, 1);
    chk("t4_remaining", bus.remaining, 12'h000);
    load(12'h000);
    go(e0);
    wait_done(e0);
    chk("t4_zero_latency", last_done - e0, 0);
    idle(2);
    load(12'h001);
    go(e0);
    idle(3);
    drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
    idle(3);
    chk("t5_no_done_on_stop", last_done < e0, 1);
    chk("t5_stop_remaining", bus.remaining, 12'h000);
    load(12'h001);
    go(e0);
    idle(3);
    drive(1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    wait_done(e0);
    chk("t5_pause_final_tick", last_done - e0, 4);
    idle(2);
    load(12'h050);
    go(e0);
    idle(5);
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) < 2) do_reset();
      else begin
        if ($urandom_range(0, 7) == 0) val = 12'($urandom);
        else if ($urandom_range(0, 19) == 0) val = to_bcd($urandom_range(0, 120));
        else val = to_bcd($urandom_range(0, 25));
        drive($urandom_range(0, 3) == 0, val, $urandom_range(0, 5) == 0,
              $urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0);
      end
    end
    idle(5);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
